// File: rtl/clock_pkg.sv
// Shared types and limits for the digital clock timekeeping slice.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

endpackage

// File: rtl/bcd_counter.sv
// Two-digit BCD modulo counter, 0..MAX, with synchronous clear and a
// combinational carry out when incrementing at MAX.
module bcd_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       carry
);

  localparam bcd_t MAX_T = bcd_t'(MAX / 10);
  localparam bcd_t MAX_U = bcd_t'(MAX % 10);

  logic at_max;

  // Wrap is decided on the full two-digit value, not on units alone.
  assign at_max = (tens == MAX_T) && (units == MAX_U);
  assign carry  = inc & at_max;

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      tens  <= '0;
      units <= '0;
    end else if (clr) begin
      tens  <= '0;
      units <= '0;
    end else if (inc) begin
      if (at_max) begin
        tens  <= '0;
        units <= '0;
      end else if (units == 4'd9) begin
        units <= '0;
        tens  <= tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// Run/set-mode controller: second-edge detect, mode FSM, blink, and the
// inc/clr steering into the seconds, minutes and hours counters.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hour_t,
  output logic [3:0] hour_u,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic [1:0] mode,
  output logic       blank_h,
  output logic       blank_m
);

  state_t state, next_state;
  logic   tick_q, sec_edge, blink;
  logic   sec_inc, sec_clr, sec_carry;
  logic   min_inc, min_carry;
  logic   hour_inc, hour_carry;

  // Loading tick_in during reset keeps release from looking like an edge.
  always_ff @(posedge clk_in) begin
    if (!rst) tick_q <= tick_in;
    else      tick_q <= tick_in;
  end

  assign sec_edge = tick_in & ~tick_q;

  always_ff @(posedge clk_in) begin
    if (!rst) state <= RUN;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:      if (btn_mode) next_state = SET_HOUR;
      SET_HOUR: if (btn_mode) next_state = SET_MIN;
      SET_MIN:  if (btn_mode) next_state = RUN;
      default:  next_state = RUN;
    endcase
  end

  // A mode press drops a coincident increment; leaving SET_MIN clears seconds.
  assign sec_inc  = (state == RUN) & sec_edge;
  assign sec_clr  = (state == SET_MIN) & btn_mode;
  assign min_inc  = (state == RUN) ? sec_carry
                                   : ((state == SET_MIN) & btn_inc & ~btn_mode);
  assign hour_inc = (state == RUN) ? min_carry
                                   : ((state == SET_HOUR) & btn_inc & ~btn_mode);

  always_ff @(posedge clk_in) begin
    if (!rst)
      blink <= 1'b0;
    else if (next_state != state)
      blink <= 1'b0;
    else if (((state == SET_HOUR) || (state == SET_MIN)) && sec_edge)
      blink <= ~blink;
  end

  bcd_counter #(.MAX(SEC_MAX)) u_sec (
    .clk_in (clk_in),
    .rst    (rst),
    .inc    (sec_inc),
    .clr    (sec_clr),
    .tens   (sec_t),
    .units  (sec_u),
    .carry  (sec_carry)
  );

  bcd_counter #(.MAX(MIN_MAX)) u_min (
    .clk_in (clk_in),
    .rst    (rst),
    .inc    (min_inc),
    .clr    (1'b0),
    .tens   (min_t),
    .units  (min_u),
    .carry  (min_carry)
  );

  bcd_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk_in (clk_in),
    .rst    (rst),
    .inc    (hour_inc),
    .clr    (1'b0),
    .tens   (hour_t),
    .units  (hour_u),
    .carry  (hour_carry)
  );

  assign mode    = state;
  assign blank_h = (state == SET_HOUR) & blink;
  assign blank_m = (state == SET_MIN) & blink;

endmodule
